// File: rtl/dmem_pkg.sv
// Shared types and defaults for the wait-stated data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [31:0] DATA_BASE  = 32'h1001_0000;
  localparam int          DMEM_DEPTH = 2048;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_ram_1rw.sv
// Single-port word RAM: synchronous write, registered read that holds while re=0.
module dmem_ram_1rw #(
  parameter int DEPTH = 2048,
  parameter int IDX_W = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wd,
  output logic [31:0]      rd
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[idx] <= wd;
    if (re) rd <= r_mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: zero-wait word writes, reads after RD_LATENCY cycles,
// with range/alignment/conflict checking reported as a one-cycle err pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DATA_BASE,
  parameter int          DEPTH_WORDS = DMEM_DEPTH,
  parameter int          RD_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_CS,
  input  logic        DM_W,
  input  logic        DM_R,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int          IDX_W    = idx_width(DEPTH_WORDS);
  localparam logic [31:0] LIMIT    = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT = 4'((RD_LATENCY >= 2) ? RD_LATENCY - 2 : 0);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_err;
  logic             r_rd_clr;

  logic [31:0]      w_offset;
  logic [31:0]      w_ram_rd;
  logic [IDX_W-1:0] w_idx, w_ram_idx;
  logic             w_idle, w_req, w_ok, w_we, w_re, w_rd_acc, w_bad;

  assign w_offset = addr - BASE_ADDR;
  assign w_idx    = w_offset[IDX_W+1:2];
  assign w_idle   = (r_state == IDLE);
  assign w_req    = DM_CS && (DM_W || DM_R);
  assign w_ok     = (w_offset < LIMIT) && (w_offset[1:0] == 2'b00) && !(DM_W && DM_R);
  assign w_we     = !rst && w_idle && w_req && w_ok && DM_W;
  assign w_rd_acc = w_idle && w_req && w_ok && DM_R;
  assign w_bad    = w_idle && w_req && !w_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_rd_acc) begin
          if (RD_LATENCY == 1) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The RAM is read on the edge that enters DONE so its output register is
  // the returned word; in IDLE the live index is used (RD_LATENCY==1 path).
  assign w_re      = !rst && (w_state_nxt == DONE);
  assign w_ram_idx = w_idle ? w_idx : r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_err    <= 1'b0;
      r_rd_clr <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_bad;
      if (w_bad)     r_rd_clr <= 1'b1;
      else if (w_re) r_rd_clr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_acc) r_idx <= w_idx;
  end

  dmem_ram_1rw #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk (clk),
    .we  (w_we),
    .re  (w_re),
    .idx (w_ram_idx),
    .wd  (wdata),
    .rd  (w_ram_rd)
  );

  assign ready = rst || (r_state == DONE) || (w_idle && !w_rd_acc);
  assign rdata = r_rd_clr ? 32'd0 : w_ram_rd;
  assign err   = r_err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the CPU data-memory interface (DM_CS/DM_W/DM_R/addr/wdata/rdata). It replaces the zero-latency data memory with a wait-stated responder. The CPU presents byte addresses in the data segment; the block translates them to word indices, range-checks them and serves word writes in one cycle. Word reads complete after a configurable latency, signalled by a ready handshake. It sits between the cpu instance and the top level, in place of the direct DMEM hookup.

Parameters:
BASE_ADDR, 32'h1001_0000, byte address of data word 0
DEPTH_WORDS, 2048, number of 32-bit words (index width = clog2, 11 at default)
RD_LATENCY, 2, cycles from read acceptance to rdata valid (legal 1..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
DM_CS  input  1  request select; no request when low
DM_W  input  1  write request (qualified by DM_CS)
DM_R  input  1  read request (qualified by DM_CS)
addr  input  32  byte address from CPU
wdata  input  32  write data
rdata  output  32  read data, valid when ready=1 for an accepted read
ready  output  1  combinational; 1 = current request completes this cycle (CPU stalls while 0)
err  output  1  one-cycle pulse: accepted request was out of range, misaligned or W+R conflict

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, latency counter=0, rdata=0, err=0. RAM contents are not cleared. Reset during WAIT aborts the read with no response. ready is 1 while rst=1.
- offset = addr - BASE_ADDR (32-bit wrap). Request valid when offset < DEPTH_WORDS*4, offset[1:0]==0, and not (DM_W && DM_R). Word index = offset[clog2(DEPTH_WORDS)+1:2].
- States: IDLE, WAIT, DONE.
- IDLE, no request (DM_CS=0, or DM_W=DM_R=0): ready=1, stay.
- IDLE, valid write: ready=1 combinationally. RAM[index]<=wdata at this edge. Stay IDLE. Zero wait states.
- IDLE, valid read: ready=0 and the index is latched.
  - RD_LATENCY==1: go to DONE.
  - Otherwise: go to WAIT with counter=RD_LATENCY-2.
- WAIT: ready=0. Decrement the counter; at 0 go to DONE.
- DONE: rdata=RAM[latched index] (registered), ready=1. Next edge goes to IDLE. rdata holds its value until the next read completes.
- Total read: ready low for exactly RD_LATENCY cycles, then high for 1 cycle.
- Invalid request in IDLE: ready=1 immediately. No RAM write. rdata<=0. err=1 on the following cycle for one cycle. Stay IDLE.
- The CPU holds addr/DM_* stable while ready=0. Inputs are ignored in WAIT/DONE (the latched index is used).
- Back-to-back: the cycle after DONE is IDLE and can accept a new request. A read following a write to the same word returns the new data.
- RAM port: single read/write. Reads and writes never overlap, because writes are only accepted in IDLE.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, WAIT, DONE}
  - localparam DATA_BASE=32'h1001_0000
  - localparam DMEM_DEPTH=2048
  - function for index width
- Sub-module dmem_ram_1rw: synchronous-write, synchronous-read word RAM (clk, we, idx, wd, rd) with no reset on the array. The FSM, address check and err generation stay in dmem_responder.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then DM_CS=0 -> ready=1, rdata=0, err=0.
- Write then read, RD_LATENCY=2: write addr=0x1001_0008, wdata=0xDEADBEEF -> ready=1 the same cycle. Then read 0x1001_0008 -> ready=0 for 2 cycles, then ready=1 with rdata=0xDEADBEEF, err never set.
- Boundaries: write 0xA5A5A5A5 to 0x1001_1FFC (last word) and read it back -> value matches. Access 0x1001_2000 -> ready=1 immediately, err pulse 1 cycle, rdata=0, word 0 unchanged.
- Misaligned and conflict cases, each giving 1 err pulse with no RAM change:
  - addr=0x1001_0002 with a write.
  - DM_W=DM_R=1 at 0x1001_0000.
  - addr=0x1000_FFFC (below base, wraps to a huge offset).
- Reset mid-read: start a read of a word holding 0x12345678 and assert rst in WAIT -> next cycle IDLE, ready=1, rdata=0. A re-read returns 0x12345678 (RAM preserved).
- Latency sweep RD_LATENCY=1 and 5: back-to-back reads of words 0 and 1 -> ready low for exactly 1 and 5 cycles per read. Second read accepted the cycle after DONE, with correct data.
